// File: rtl/mem_moc_responder.sv
// Byte-addressed big-endian memory answering multicycle-controller requests.
// Each access completes a fixed number of cycles after capture and raises MOC until memEnable drops.
module mem_moc_responder #(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memEnable,
  input  logic        RW,
  input  logic        byteAcc,
  input  logic        unSign,
  input  logic [31:0] address,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        MOC,
  output logic        addrErr
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [AW-1:0]   addr_p0;
  logic            rw_p0;
  logic            byte_p0;
  logic            unsign_p0;
  logic            mis_p0;
  logic [31:0]     wdata_p0;
  logic [7:0]      mem [DEPTH];

  logic [AW-1:0]   w0, w1, w2, w3;
  logic [31:0]     rdata;
  logic            do_access;
  logic            unused_addr_hi;

  assign unused_addr_hi = ^address[31:AW];

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic zext);
    ext_byte = {{24{b[7] & ~zext}}, b};
  endfunction

  // Word accesses are aligned down; the index wraps modulo DEPTH.
  assign w0 = addr_p0 & ~AW'(3);
  assign w1 = w0 | AW'(1);
  assign w2 = w0 | AW'(2);
  assign w3 = w0 | AW'(3);

  assign rdata = byte_p0 ? ext_byte(mem[addr_p0], unsign_p0)
                         : {mem[w0], mem[w1], mem[w2], mem[w3]};

  assign do_access = (state == BUSY) && memEnable && (cnt == 4'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      MOC       <= 1'b0;
      addrErr   <= 1'b0;
      dataOut   <= 32'd0;
      addr_p0   <= '0;
      rw_p0     <= 1'b0;
      byte_p0   <= 1'b0;
      unsign_p0 <= 1'b0;
      mis_p0    <= 1'b0;
      wdata_p0  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          MOC     <= 1'b0;
          addrErr <= 1'b0;
          if (memEnable) begin
            addr_p0   <= address[AW-1:0];
            rw_p0     <= RW;
            byte_p0   <= byteAcc;
            unsign_p0 <= unSign;
            mis_p0    <= !byteAcc && (address[1:0] != 2'b00);
            wdata_p0  <= dataIn;
            cnt       <= 4'(LATENCY - 1);
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (!memEnable) begin
            state <= IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!rw_p0) begin
              dataOut <= rdata;
              addrErr <= mis_p0;
            end else begin
              addrErr <= mis_p0;
            end
            MOC   <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (!memEnable) begin
            MOC     <= 1'b0;
            addrErr <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The array is never reset; a write lands on the completing edge only.
  always_ff @(posedge clk) begin
    if (do_access && rw_p0) begin
      if (byte_p0) begin
        mem[addr_p0] <= wdata_p0[7:0];
      end else begin
        mem[w0] <= wdata_p0[31:24];
        mem[w1] <= wdata_p0[23:16];
        mem[w2] <= wdata_p0[15:8];
        mem[w3] <= wdata_p0[7:0];
      end
    end
  end

endmodule

// File: tb/tb_mem_moc_responder.sv
// Directed self-checking bench for mem_moc_responder (LATENCY=3, DEPTH=512).
module tb_mem_moc_responder;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        memEnable;
  logic        RW;
  logic        byteAcc;
  logic        unSign;
  logic [31:0] address;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic        MOC;
  logic        addrErr;

  int checks = 0;
  int errors = 0;

  mem_moc_responder #(.DEPTH(512), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .memEnable(memEnable), .RW(RW), .byteAcc(byteAcc),
    .unSign(unSign), .address(address), .dataIn(dataIn), .dataOut(dataOut),
    .MOC(MOC), .addrErr(addrErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for MOC (bounded), then drop memEnable for one edge.
  task automatic access(input logic rw, input logic b, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] dout, output logic err);
    @(negedge clk);
    RW = rw; byteAcc = b; unSign = u; address = a; dataIn = d; memEnable = 1'b1;
    lat = -1;
    dout = 32'hx;
    err = 1'bx;
    for (int n = 0; n <= 20; n++) begin
      @(posedge clk); #1;
      if (MOC === 1'b1) begin
        lat = n;
        break;
      end
    end
    dout = dataOut;
    err = addrErr;
    @(negedge clk);
    memEnable = 1'b0;
    @(posedge clk); #1;
  endtask

  int          lat;
  logic [31:0] dout;
  logic        err;
  bit          saw_moc;

  initial begin
    reset = 1'b0; memEnable = 1'b0; RW = 1'b0; byteAcc = 1'b0; unSign = 1'b0;
    address = 32'd0; dataIn = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_moc", {31'd0, MOC}, 32'd0);
    chk("reset_dout", dataOut, 32'd0);
    chk("reset_err", {31'd0, addrErr}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // word write then word read at 0x10
    access(1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, lat, dout, err);
    chk("ww10_lat", lat, LAT);
    chk("ww10_dout_unchanged", dout, 32'd0);
    chk("ww10_moc_drop", {31'd0, MOC}, 32'd0);
    access(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, lat, dout, err);
    chk("wr10_lat", lat, LAT);
    chk("wr10_data", dout, 32'hDEADBEEF);
    chk("wr10_err", {31'd0, err}, 32'd0);
    access(1'b0, 1'b1, 1'b1, 32'h10, 32'h0, lat, dout, err);
    chk("br10_msb", dout, 32'h000000DE);
    access(1'b0, 1'b1, 1'b1, 32'h13, 32'h0, lat, dout, err);
    chk("br13_lsb", dout, 32'h000000EF);

    // byte write into a known word, sign/zero extension
    access(1'b1, 1'b0, 1'b0, 32'h20, 32'h11223344, lat, dout, err);
    access(1'b1, 1'b1, 1'b0, 32'h21, 32'hFFFFFF80, lat, dout, err);
    chk("bw21_lat", lat, LAT);
    access(1'b0, 1'b1, 1'b0, 32'h21, 32'h0, lat, dout, err);
    chk("br21_sext", dout, 32'hFFFFFF80);
    access(1'b0, 1'b1, 1'b1, 32'h21, 32'h0, lat, dout, err);
    chk("br21_zext", dout, 32'h00000080);
    access(1'b0, 1'b0, 1'b0, 32'h20, 32'h0, lat, dout, err);
    chk("wr20_merge", dout, 32'h11803344);

    // misaligned word read
    access(1'b0, 1'b0, 1'b0, 32'h13, 32'h0, lat, dout, err);
    chk("wr13_data", dout, 32'hDEADBEEF);
    chk("wr13_err", {31'd0, err}, 32'd1);
    chk("wr13_err_clr", {31'd0, addrErr}, 32'd0);

    // abort by dropping memEnable one cycle into BUSY
    @(negedge clk);
    RW = 1'b1; byteAcc = 1'b0; address = 32'h10; dataIn = 32'hCAFEF00D; memEnable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    memEnable = 1'b0;
    saw_moc = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (MOC !== 1'b0) saw_moc = 1'b1;
    end
    chk("abort_no_moc", {31'd0, saw_moc}, 32'd0);
    access(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, lat, dout, err);
    chk("abort_old_data", dout, 32'hDEADBEEF);

    // abort by reset mid-BUSY
    @(negedge clk);
    RW = 1'b1; byteAcc = 1'b0; address = 32'h10; dataIn = 32'hCAFEF00D; memEnable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    memEnable = 1'b0;
    #1;
    chk("rst_abort_moc", {31'd0, MOC}, 32'd0);
    chk("rst_abort_dout", dataOut, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    access(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, lat, dout, err);
    chk("rst_abort_old_data", dout, 32'hDEADBEEF);

    // wrap-around modulo DEPTH
    access(1'b1, 1'b0, 1'b0, 32'h00000204, 32'h12345678, lat, dout, err);
    access(1'b0, 1'b0, 1'b0, 32'h00000004, 32'h0, lat, dout, err);
    chk("wrap_data", dout, 32'h12345678);

    // hold memEnable in DONE: no second access
    @(negedge clk);
    RW = 1'b0; byteAcc = 1'b0; address = 32'h4; memEnable = 1'b1;
    saw_moc = 1'b0;
    for (int n = 0; n <= 20; n++) begin
      @(posedge clk); #1;
      if (MOC === 1'b1) begin
        saw_moc = 1'b1;
        break;
      end
    end
    chk("hold_moc_seen", {31'd0, saw_moc}, 32'd1);
    @(negedge clk);
    address = 32'h10;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold_moc", {31'd0, MOC}, 32'd1);
      chk("hold_dout", dataOut, 32'h12345678);
    end
    @(negedge clk);
    memEnable = 1'b0;
    @(posedge clk); #1;
    chk("hold_drop_moc", {31'd0, MOC}, 32'd0);
    access(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, lat, dout, err);
    chk("reraise_lat", lat, LAT);
    chk("reraise_data", dout, 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_moc_responder.md
Name: mem_moc_responder

Overview:
- Byte-addressed data/instruction memory that answers the multicycle control unit's memory requests.
- The controller drives memEnable, RW, byte and unSign, and supplies the address from MAR and the write data from MDR.
- This block performs the access after a programmable latency and raises MOC (memory operation complete). It holds MOC until the controller drops memEnable.
- Word layout is big-endian: mem[a] holds bits 31:24 of the word.

Parameters:
- DEPTH, 512, number of bytes of storage; must be a power of two and at least 4.
- LATENCY, 2, clock cycles from request capture to MOC assertion; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- memEnable  input  1  request strobe; level-held by the controller until it sees MOC.
- RW  input  1  0 = read, 1 = write.
- byte  input  1  1 = byte access, 0 = word access.
- unSign  input  1  byte read only: 1 = zero-extend, 0 = sign-extend.
- address  input  32  byte address.
- dataIn  input  32  write data; bits 7:0 are used for byte writes.
- dataOut  output  32  read data, valid while MOC=1 after a read.
- MOC  output  1  operation complete.
- addrErr  output  1  word access with address[1:0]!=0, pulsed with MOC.

Behaviour:
- Reset values (reset=0): MOC=0, dataOut=0, addrErr=0, state=IDLE, latency counter=0.
  - Memory array contents are not cleared by reset.
  - Reset asserted mid-operation aborts the access immediately. A pending write is not performed.
- Address mapping:
  - Effective byte index = address[log2(DEPTH)-1:0]. Higher address bits are ignored, so accesses wrap modulo DEPTH.
  - Word accesses use the index with bits 1:0 forced to 0 (aligned down).
  - addrErr=1 is driven for the same cycles as MOC when a word access had address[1:0]!=0. The access still completes.
- State machine: IDLE, BUSY, DONE.
  - IDLE:
    - MOC=0.
    - If memEnable=1 at a rising edge: latch address, RW, byte, unSign and dataIn; load counter with LATENCY-1; go to BUSY.
    - Inputs are not sampled again until the next IDLE.
  - BUSY:
    - If memEnable=0 at an edge: abort (no write, MOC stays 0) and return to IDLE.
    - Else if counter!=0: decrement the counter.
    - Else perform the access on this edge: write the array, or load dataOut and addrErr. Set MOC=1 and go to DONE.
    - With LATENCY=1, MOC rises on the edge after the capture edge. With LATENCY=N, MOC rises N edges after capture.
  - DONE:
    - MOC=1, and dataOut and addrErr are held stable.
    - When memEnable=0 at an edge: MOC=0, addrErr=0, go to IDLE. dataOut keeps its last value.
    - While memEnable stays 1, no new access starts. Each request requires memEnable to drop and rise again.
- Read data:
  - Word read: dataOut = {mem[i], mem[i+1], mem[i+2], mem[i+3]}.
  - Byte read: dataOut = mem[i] in bits 7:0. Bits 31:8 are 0 if unSign=1, otherwise a copy of mem[i][7].
- Write:
  - Word write: mem[i..i+3] = dataIn[31:24], [23:16], [15:8], [7:0].
  - Byte write: mem[i] = dataIn[7:0] only; neighbouring bytes are unchanged.
  - After a write, dataOut is not changed.
- Simultaneous events:
  - memEnable falling on the same edge that the counter reaches 0 counts as an abort; memEnable is checked first.
  - A request arriving on the edge DONE returns to IDLE is not captured. It is captured on the following edge if memEnable is still 1.

Test Plan:
- Reset, then word write 0xDEADBEEF at address 0x10, then word read at 0x10 → MOC rises LATENCY edges after capture; dataOut=0xDEADBEEF; mem[0x10]=0xDE, mem[0x13]=0xEF.
- Byte write 0x80 at 0x21, then byte read at 0x21 with unSign=0 → dataOut=0xFFFFFF80. Repeat with unSign=1 → dataOut=0x00000080. Word read at 0x20 shows only byte 1 changed.
- Word read at 0x13 (misaligned) → data comes from 0x10, addrErr=1 while MOC=1, addrErr=0 after memEnable drops.
- Word write at 0x10 with memEnable dropped during BUSY (LATENCY=3, drop after 1 cycle) → MOC never rises; a later read of 0x10 returns the old value. Repeat with reset pulled low mid-BUSY: same result, MOC=0 and dataOut=0 immediately.
- DEPTH=512, word write 0x12345678 at 0x00000204, read at 0x00000004 → dataOut=0x12345678 (wrap-around).
- Hold memEnable high for 5 cycles after MOC → MOC stays 1 with no second access. Drop memEnable → MOC=0 on the next edge. A re-raise then starts a new request with the same latency.
